mem_region_decoder: RTL and testbench

- Parametrised, pipelined virtual-to-physical address decoder for the MIPS32 SoC data path.
- Sits between the core load/store unit and data memory.
- Matches a request address against NUM_REGIONS windows and applies per-region relocation. Checks alignment against access size and enforces read-only regions.
- Returns a registered response through a valid/ready handshake, and latches the first fault in a sticky status register, in the same way as BadVAddr.

---
 rtl/memdec_pkg.sv | 27 ++
 rtl/mem_region_match.sv | 43 ++++
 rtl/mem_region_decoder.sv | 154 +++++++++++++++
 tb/tb_mem_region_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memdec_pkg.sv
// memdec_pkg: shared encodings and helpers for the memory region decoder.
//   cause_e : fault cause codes reported on resp_cause / fault_cause
//   size_e  : access size codes carried on req_size (2'b11 is illegal)
//   clog2   : constant-evaluable ceiling log2 used to size the region index
package memdec_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_UNMAPPED   = 2'b01,
    CAUSE_MISALIGNED = 2'b10,
    CAUSE_RO_WRITE   = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// mem_region_match: combinational address window matcher and relocator.
//   addr  in  32     virtual address
//   hit   out 1      some window contains addr
//   idx   out RID_W  lowest-index window containing addr (0 on miss)
//   phys  out PA_W   REGION_PHYS[idx] + addr - REGION_BASE[idx] (0 on miss)
module mem_region_match
  import memdec_pkg::*;
#(
  parameter int unsigned                   NUM_REGIONS = 2,
  parameter int unsigned                   PA_W        = 13,
  parameter int unsigned                   RID_W       = 1,
  parameter logic [NUM_REGIONS*32-1:0]     REGION_BASE = {32'h7FFFEFFC, 32'h10010000},
  parameter logic [NUM_REGIONS*32-1:0]     REGION_SIZE = {32'h1000, 32'h1000},
  parameter logic [NUM_REGIONS*32-1:0]     REGION_PHYS = {32'h1000, 32'h0}
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [RID_W-1:0] idx,
  output logic [PA_W-1:0]  phys
);

  logic [31:0] base;
  logic [32:0] limit;

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    phys  = '0;
    base  = '0;
    limit = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      base  = REGION_BASE[i*32 +: 32];
      // 33-bit end so a window reaching 0xFFFFFFFF does not wrap to zero
      limit = {1'b0, base} + {1'b0, REGION_SIZE[i*32 +: 32]};
      if (!hit && (addr >= base) && ({1'b0, addr} < limit)) begin
        hit  = 1'b1;
        idx  = RID_W'(i);
        phys = PA_W'(REGION_PHYS[i*32 +: 32] + addr - base);
      end
    end
  end

endmodule

// File: rtl/mem_region_decoder.sv
// mem_region_decoder: pipelined virtual-to-physical decoder for the data path.
// Matches req_addr against NUM_REGIONS windows, relocates, checks alignment
// and read-only regions, and returns a registered response (1-cycle latency,
// single output register, valid/ready both sides). The first fault is latched
// in a sticky status register; later faults bump a saturating overflow count.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_addr, req_size, req_write request fields
//   resp_valid/resp_ready        response handshake
//   resp_phys_addr, resp_region, resp_fault, resp_cause  response fields
//   fault_valid, fault_addr, fault_cause, fault_ovf, fault_clr  sticky status
//   hit_cnt                      per-region 16-bit hit counters
// Optional: define MEMDEC_HIT_CNT_EN to add hit_cnt and its counters.
module mem_region_decoder
  import memdec_pkg::*;
#(
  parameter int unsigned               NUM_REGIONS = 2,
  parameter int unsigned               PA_W        = 13,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h7FFFEFFC, 32'h10010000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_SIZE = {32'h1000, 32'h1000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_PHYS = {32'h1000, 32'h0},
  parameter logic [NUM_REGIONS-1:0]    REGION_RO   = '0,
  localparam int unsigned              RID_W = (NUM_REGIONS > 1) ? clog2(NUM_REGIONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic             req_write,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [PA_W-1:0]  resp_phys_addr,
  output logic [RID_W-1:0] resp_region,
  output logic             resp_fault,
  output logic [1:0]       resp_cause,
  output logic             fault_valid,
  output logic [31:0]      fault_addr,
  output logic [1:0]       fault_cause,
  input  logic             fault_clr,
  output logic [7:0]       fault_ovf
`ifdef MEMDEC_HIT_CNT_EN
  ,
  output logic [NUM_REGIONS*16-1:0] hit_cnt
`endif
);

  logic             match_hit;
  logic [RID_W-1:0] match_idx;
  logic [PA_W-1:0]  match_phys;
  logic             misaligned;
  logic             accept;
  logic             is_fault;
  cause_e           cause;

  // Padded to the full index range so any idx value selects a defined bit
  localparam logic [(2**RID_W)-1:0] RO_VEC = (2**RID_W)'(REGION_RO);

  mem_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .PA_W        (PA_W),
    .RID_W       (RID_W),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE),
    .REGION_PHYS (REGION_PHYS)
  ) u_match (
    .addr (req_addr),
    .hit  (match_hit),
    .idx  (match_idx),
    .phys (match_phys)
  );

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    cause = CAUSE_NONE;
    if (!match_hit)                       cause = CAUSE_UNMAPPED;
    else if (misaligned)                  cause = CAUSE_MISALIGNED;
    else if (req_write && RO_VEC[match_idx]) cause = CAUSE_RO_WRITE;
  end

  assign is_fault = (cause != CAUSE_NONE);

  // Response register: loads on accept, drains when the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid     <= 1'b0;
      resp_phys_addr <= '0;
      resp_region    <= '0;
      resp_fault     <= 1'b0;
      resp_cause     <= '0;
    end else if (accept) begin
      resp_valid     <= 1'b1;
      resp_phys_addr <= match_phys;
      resp_region    <= match_idx;
      resp_fault     <= is_fault;
      resp_cause     <= cause;
    end else if (resp_ready) begin
      resp_valid     <= 1'b0;
    end
  end

  // Sticky fault: a clear in the same cycle as a new fault acts first, so the
  // new fault is then treated as the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= '0;
      fault_ovf   <= '0;
    end else begin
      if (fault_clr) begin
        fault_valid <= 1'b0;
        fault_ovf   <= '0;
      end
      if (accept && is_fault) begin
        if (!fault_valid || fault_clr) begin
          fault_valid <= 1'b1;
          fault_addr  <= req_addr;
          fault_cause <= cause;
        end else if (fault_ovf != 8'hFF) begin
          fault_ovf <= fault_ovf + 8'd1;
        end
      end
    end
  end

`ifdef MEMDEC_HIT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (accept && !is_fault) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        if (match_idx == RID_W'(i))
          hit_cnt[i*16 +: 16] <= hit_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_region_decoder.sv
// tb_mem_region_decoder: directed self-checking bench for mem_region_decoder.
// DUT built with REGION_RO = 2'b01 (region 0 read-only); other params default.
module tb_mem_region_decoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_write;
  logic        resp_valid;
  logic        resp_ready;
  logic [12:0] resp_phys_addr;
  logic [0:0]  resp_region;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;
  logic        fault_clr;
  logic [7:0]  fault_ovf;
`ifdef MEMDEC_HIT_CNT_EN
  logic [31:0] hit_cnt;
`endif

  int unsigned total;
  int unsigned bad;

  mem_region_decoder #(
    .REGION_RO (2'b01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_write      (req_write),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_phys_addr (resp_phys_addr),
    .resp_region    (resp_region),
    .resp_fault     (resp_fault),
    .resp_cause     (resp_cause),
    .fault_valid    (fault_valid),
    .fault_addr     (fault_addr),
    .fault_cause    (fault_cause),
    .fault_clr      (fault_clr),
    .fault_ovf      (fault_ovf)
`ifdef MEMDEC_HIT_CNT_EN
    ,
    .hit_cnt        (hit_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted request; outputs are sampled 1 time unit after the edge
  task automatic req(input logic [31:0] a, input logic [1:0] s, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_write = w;
    step();
    req_valid = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [12:0] pa, input logic rg,
                          input logic [1:0] cs);
    chk({tag, ".valid"},  {31'd0, resp_valid}, 32'd1);
    chk({tag, ".phys"},   {19'd0, resp_phys_addr}, {19'd0, pa});
    chk({tag, ".region"}, {31'd0, resp_region}, {31'd0, rg});
    chk({tag, ".fault"},  {31'd0, resp_fault}, {31'd0, (cs != 2'b00)});
    chk({tag, ".cause"},  {30'd0, resp_cause}, {30'd0, cs});
  endtask

  task automatic chk_sticky(input string tag, input logic v, input logic [31:0] a,
                            input logic [1:0] c, input logic [7:0] o);
    chk({tag, ".fv"},   {31'd0, fault_valid}, {31'd0, v});
    chk({tag, ".fa"},   fault_addr, a);
    chk({tag, ".fc"},   {30'd0, fault_cause}, {30'd0, c});
    chk({tag, ".ovf"},  {24'd0, fault_ovf}, {24'd0, o});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rv"},   {31'd0, resp_valid}, 32'd0);
    chk({tag, ".pa"},   {19'd0, resp_phys_addr}, 32'd0);
    chk({tag, ".rg"},   {31'd0, resp_region}, 32'd0);
    chk({tag, ".rf"},   {31'd0, resp_fault}, 32'd0);
    chk({tag, ".rc"},   {30'd0, resp_cause}, 32'd0);
    chk_sticky(tag, 1'b0, 32'd0, 2'b00, 8'd0);
`ifdef MEMDEC_HIT_CNT_EN
    chk({tag, ".hc"},   hit_cnt, 32'd0);
`endif
  endtask

  task automatic clear_pulse();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = 2'b10;
    req_write  = 1'b0;
    resp_ready = 1'b1;
    fault_clr  = 1'b0;

    step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Region 0 basic translation
    req(32'h10010010, 2'b10, 1'b0);
    chk_resp("r0_word", 13'h0010, 1'b0, 2'b00);
    chk("r0_ready", {31'd0, req_ready}, 32'd1);

    // Region 1 start, last word, first address past the window
    req(32'h7FFFEFFC, 2'b10, 1'b0);
    chk_resp("r1_lo", 13'h1000, 1'b1, 2'b00);
    req(32'h7FFFFFF8, 2'b10, 1'b0);
    chk_resp("r1_hi", 13'h1FFC, 1'b1, 2'b00);
    req(32'h7FFFFFFC, 2'b10, 1'b0);
    chk_resp("r1_past", 13'h0000, 1'b0, 2'b01);
    chk_sticky("unmap", 1'b1, 32'h7FFFFFFC, 2'b01, 8'd0);
    step();
    chk("idle_drain", {31'd0, resp_valid}, 32'd0);
    clear_pulse();
    chk_sticky("clr1", 1'b0, 32'h7FFFFFFC, 2'b01, 8'd0);

    // Misalignment, first fault sticks, overflow counts
    req(32'h10010001, 2'b01, 1'b0);
    chk_resp("half_mis", 13'h0001, 1'b0, 2'b10);
    chk_sticky("mis1", 1'b1, 32'h10010001, 2'b10, 8'd0);
    req(32'h10010002, 2'b10, 1'b0);
    chk_resp("word_mis", 13'h0002, 1'b0, 2'b10);
    chk_sticky("mis2", 1'b1, 32'h10010001, 2'b10, 8'd1);
    req(32'h10010003, 2'b00, 1'b0);
    chk_resp("byte_ok", 13'h0003, 1'b0, 2'b00);
    req(32'h10010000, 2'b11, 1'b0);
    chk_resp("size11", 13'h0000, 1'b0, 2'b10);
    chk_sticky("mis3", 1'b1, 32'h10010001, 2'b10, 8'd2);

    // Read-only region 0 store; region 1 store is allowed
    req(32'h10010000, 2'b10, 1'b1);
    chk_resp("ro_wr", 13'h0000, 1'b0, 2'b11);
    chk("ro_ovf", {24'd0, fault_ovf}, 32'd3);
    req(32'h7FFFF000, 2'b10, 1'b1);
    chk_resp("rw_wr", 13'h1004, 1'b1, 2'b00);
    // Priority: misaligned beats RO write, unmapped beats misaligned
    req(32'h10010001, 2'b01, 1'b1);
    chk_resp("prio_mis", 13'h0001, 1'b0, 2'b10);
    req(32'h00000001, 2'b01, 1'b0);
    chk_resp("prio_unm", 13'h0000, 1'b0, 2'b01);
    chk("prio_ovf", {24'd0, fault_ovf}, 32'd5);

    // Clear coinciding with a new fault: new fault loads, ovf zero
    fault_clr = 1'b1;
    req(32'h00000000, 2'b00, 1'b0);
    fault_clr = 1'b0;
    chk_sticky("clr_new", 1'b1, 32'h00000000, 2'b01, 8'd0);
    clear_pulse();
    chk_sticky("clr2", 1'b0, 32'h00000000, 2'b01, 8'd0);

    // Backpressure: A accepted, B held for 3 stalled cycles, then B and C
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h7FFFF000;
    req_size   = 2'b10;
    req_write  = 1'b0;
    step();
    req_addr = 32'h7FFFF004;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk_resp("stall_A", 13'h1004, 1'b1, 2'b00);
      step();
    end
    resp_ready = 1'b1;
    #1;
    chk("release_ready", {31'd0, req_ready}, 32'd1);
    step();
    chk_resp("resp_B", 13'h1008, 1'b1, 2'b00);
    req_addr = 32'h7FFFF008;
    step();
    chk_resp("resp_C", 13'h100C, 1'b1, 2'b00);
    req_valid = 1'b0;
    step();
    chk("after_C", {31'd0, resp_valid}, 32'd0);

    // Async reset while a faulting response is stalled and sticky is set
    resp_ready = 1'b0;
    req(32'h00000010, 2'b10, 1'b0);
    chk_resp("pre_rst", 13'h0000, 1'b0, 2'b01);
    chk("pre_rst.fv", {31'd0, fault_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    step();
    rst        = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req(32'h7FFFF000 + 32'(i * 4), 2'b10, 1'b0);
    end
    chk_resp("post_rst", 13'h1014, 1'b1, 2'b00);
    req(32'h7FFFF001, 2'b10, 1'b0);
    chk_resp("post_rst_mis", 13'h1005, 1'b1, 2'b10);
`ifdef MEMDEC_HIT_CNT_EN
    chk("hit_cnt1", {16'd0, hit_cnt[31:16]}, 32'd5);
    chk("hit_cnt0", {16'd0, hit_cnt[15:0]}, 32'd0);
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
